// File: rtl/sd_cmd_engine.sv
// SD card CMD-line engine: Avalon-MM register slave, free-running SD clock,
// 48-bit command serialiser with CRC7 and optional response capture/check.
module sd_cmd_engine #(
   parameter int CLK_DIV = 125,
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        sd_clk,
   output logic        cmd_out,
   output logic        cmd_oe,
   input  logic        cmd_in
);

   localparam int              DIV_W        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CLK_DIV - 1);
   localparam logic [15:0]     TIMEOUT_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, GAP} state_t;

   state_t           state, state_next;
   logic [DIV_W-1:0] div_cnt;
   logic             div_term, tick_rise, tick_fall, cnt_evt;
   logic             wr_arg, wr_cmd, busy;
   logic [31:0]      arg_q, resp_q;
   logic [5:0]       resp_idx_q;
   logic [47:0]      tx_frame, rx_word;
   logic [46:0]      rx_sr;
   logic [15:0]      cnt;
   logic             resp_en_q, crc_ign_q;
   logic             done_q, timeout_q, crc_err_q, frame_err_q;
   logic             unused_bits;

   function automatic logic [6:0] crc7(input logic [39:0] data);
      logic [6:0] crc;
      logic       fb;
      crc = '0;
      for (int i = 39; i >= 0; i--) begin
         fb  = crc[6] ^ data[i];
         crc = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
      end
      return crc;
   endfunction

   assign wr_arg      = chipselect && !write_n && (address == 3'd0);
   assign wr_cmd      = chipselect && !write_n && (address == 3'd1);
   assign busy        = (state != IDLE);
   assign rx_word     = {rx_sr, cmd_in};
   assign unused_bits = ^writedata[31:8];

   // Ticks coincide with the clk edge on which sd_clk itself changes level.
   assign div_term  = (div_cnt == DIV_LAST);
   assign tick_rise = div_term & ~sd_clk;
   assign tick_fall = div_term & sd_clk;

   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt <= '0;
         sd_clk  <= 1'b0;
      end else if (div_term) begin
         div_cnt <= '0;
         sd_clk  <= ~sd_clk;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // NOTE: state and every register below use non-blocking assignments so all
   // flops update together from pre-edge values, regardless of block order.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // NOTE: defaults are assigned before the case so no path leaves a
   // combinational output unassigned, which would infer a latch.
   always_comb begin
      state_next = state;
      cnt_evt    = 1'b0;
      case (state)
         IDLE: if (wr_cmd) state_next = SEND;
         SEND: begin
            cnt_evt = tick_fall;
            if (tick_fall && cnt == 16'd48) state_next = resp_en_q ? WAIT : GAP;
         end
         WAIT: begin
            cnt_evt = tick_rise;
            if (tick_rise) begin
               if (!cmd_in)                    state_next = RECV;
               else if (cnt == TIMEOUT_LAST)   state_next = GAP;
            end
         end
         RECV: begin
            cnt_evt = tick_rise;
            if (tick_rise && cnt == 16'd46) state_next = GAP;
         end
         GAP: begin
            cnt_evt = tick_rise;
            if (tick_rise && cnt == 16'd7) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         arg_q       <= '0;
         tx_frame    <= '0;
         rx_sr       <= '0;
         cnt         <= '0;
         resp_en_q   <= 1'b0;
         crc_ign_q   <= 1'b0;
         resp_q      <= '0;
         resp_idx_q  <= '0;
         done_q      <= 1'b0;
         timeout_q   <= 1'b0;
         crc_err_q   <= 1'b0;
         frame_err_q <= 1'b0;
         cmd_out     <= 1'b1;
         cmd_oe      <= 1'b0;
      end else begin
         if (wr_arg) arg_q <= writedata;

         if (state_next != state) cnt <= '0;
         else if (cnt_evt)        cnt <= cnt + 16'd1;

         case (state)
            IDLE: begin
               if (wr_cmd) begin
                  // The whole frame is frozen here so later ARG writes cannot disturb it.
                  tx_frame    <= {2'b01, writedata[5:0], arg_q,
                                  crc7({2'b01, writedata[5:0], arg_q}), 1'b1};
                  resp_en_q   <= writedata[6];
                  crc_ign_q   <= writedata[7];
                  done_q      <= 1'b0;
                  timeout_q   <= 1'b0;
                  crc_err_q   <= 1'b0;
                  frame_err_q <= 1'b0;
               end
            end
            SEND: begin
               if (tick_fall) begin
                  if (cnt == 16'd48) begin
                     cmd_oe  <= 1'b0;
                     cmd_out <= 1'b1;
                  end else begin
                     cmd_oe   <= 1'b1;
                     cmd_out  <= tx_frame[47];
                     tx_frame <= {tx_frame[46:0], 1'b1};
                  end
               end
            end
            WAIT: begin
               if (tick_rise) begin
                  rx_sr <= rx_word[46:0];
                  if (cmd_in && cnt == TIMEOUT_LAST) timeout_q <= 1'b1;
               end
            end
            RECV: begin
               if (tick_rise) begin
                  rx_sr <= rx_word[46:0];
                  if (cnt == 16'd46) begin
                     frame_err_q <= rx_word[46] | ~rx_word[0];
                     crc_err_q   <= ~crc_ign_q & (crc7(rx_word[47:8]) != rx_word[7:1]);
                     resp_q      <= rx_word[39:8];
                     resp_idx_q  <= rx_word[45:40];
                  end
               end
            end
            GAP: begin
               if (tick_rise && cnt == 16'd7) done_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         readdata <= '0;
      end else begin
         case (address)
            3'd0:    readdata <= arg_q;
            3'd2:    readdata <= {27'd0, frame_err_q, crc_err_q, timeout_q, done_q, busy};
            3'd3:    readdata <= resp_q;
            3'd4:    readdata <= {26'd0, resp_idx_q};
            default: readdata <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Self-checking bench for sd_cmd_engine: pin-level frame model, SD card
// responder and register scoreboard driven by directed and random commands.
module tb_sd_cmd_engine;

   localparam int TB_DIV = 2;
   localparam int TB_TO  = 64;

   logic        clk, reset;
   logic [2:0]  address;
   logic        chipselect, write_n;
   logic [31:0] writedata, readdata;
   logic        sd_clk, cmd_out, cmd_oe, cmd_in;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic [31:0] m_arg  = '0;
   logic [31:0] m_resp = '0;
   logic [5:0]  m_idx  = '0;

   // handshake between stimulus and the pin monitor / card
   bit          start_req = 0;
   logic [47:0] req_frame, req_card_frame;
   bit          req_card_on;
   int          req_card_delay;
   bit          armed = 0, card_on = 0, frame_ended = 0;
   logic [47:0] exp_frame, card_frame;
   int          tx_idx, card_wait, card_idx = 0, rises_after_end = 0;

   sd_cmd_engine #(.CLK_DIV(TB_DIV), .TIMEOUT(TB_TO)) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .sd_clk     (sd_clk),
      .cmd_out    (cmd_out),
      .cmd_oe     (cmd_oe),
      .cmd_in     (cmd_in)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // CRC7 as polynomial long division of msg * x^7 by x^7 + x^3 + 1.
   function automatic logic [6:0] ref_crc7(input logic [39:0] msg);
      logic [46:0] rem;
      rem = {msg, 7'd0};
      for (int i = 46; i >= 7; i--)
         if (rem[i]) rem[i -: 8] = rem[i -: 8] ^ 8'h89;
      return rem[6:0];
   endfunction

   function automatic logic [47:0] make_cmd_frame(input logic [5:0] idx, input logic [31:0] arg);
      return {2'b01, idx, arg, ref_crc7({2'b01, idx, arg}), 1'b1};
   endfunction

   function automatic logic [47:0] make_resp(input logic [5:0] idx, input logic [31:0] arg);
      return {2'b00, idx, arg, ref_crc7({2'b00, idx, arg}), 1'b1};
   endfunction

   // Pin monitor and card: every clk cycle, compare the pins with the frame model.
   initial begin
      logic prev_sd, prev_out, prev_oe;
      int   half_cnt;
      bit   half_valid, fall, rise;
      prev_sd = 1'b0; prev_out = 1'b1; prev_oe = 1'b0;
      half_cnt = 0; half_valid = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            armed = 0; card_on = 0; frame_ended = 0; half_valid = 0; card_idx = 0;
            cmd_in = 1'b1;
         end else begin
            fall = prev_sd && !sd_clk;
            rise = !prev_sd && sd_clk;
            if (sd_clk !== prev_sd) begin
               if (half_valid) check("sd_clk_half_period", half_cnt, TB_DIV);
               half_valid = 1; half_cnt = 1;
            end else begin
               half_cnt++;
            end
            if ((cmd_out !== prev_out) || (cmd_oe !== prev_oe))
               check("pin_change_only_on_fall", fall, 1);
            if (fall) begin
               if (armed && tx_idx < 48) begin
                  check("cmd_oe_frame_bit", cmd_oe, 1);
                  check("cmd_out_frame_bit", cmd_out, exp_frame[47 - tx_idx]);
                  tx_idx++;
               end else begin
                  check("cmd_oe_released", cmd_oe, 0);
                  check("cmd_out_idle_high", cmd_out, 1);
                  if (armed) begin
                     armed = 0; frame_ended = 1; rises_after_end = 0;
                  end
               end
               if (card_on) begin
                  if (card_wait > 0) card_wait--;
                  else if (card_idx < 48) begin
                     cmd_in = card_frame[47 - card_idx];
                     card_idx++;
                  end else begin
                     cmd_in = 1'b1; card_on = 0;
                  end
               end
            end
            if (rise && frame_ended) rises_after_end++;
         end
         if (start_req) begin
            armed = 1; tx_idx = 0; exp_frame = req_frame;
            card_on = req_card_on; card_frame = req_card_frame;
            card_wait = req_card_delay; card_idx = 0; frame_ended = 0;
            start_req = 0;
         end
         prev_sd = sd_clk; prev_out = cmd_out; prev_oe = cmd_oe;
      end
   end

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(posedge clk); #1;
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
      @(negedge clk);
      address = a; chipselect = 1'b1; write_n = 1'b1;
      @(negedge clk); #1;
      d = readdata;
      chipselect = 1'b0;
   endtask

   task automatic start_cmd(input logic [5:0] idx, input bit resp_en, input bit crc_ign,
                            input bit card_valid, input logic [47:0] cf, input int delay);
      req_frame      = make_cmd_frame(idx, m_arg);
      req_card_on    = resp_en && card_valid;
      req_card_frame = cf;
      req_card_delay = 48 + delay;
      @(negedge clk);
      address = 3'd1; writedata = {24'd0, crc_ign, resp_en, idx};
      chipselect = 1'b1; write_n = 1'b0;
      @(posedge clk); #1;
      chipselect = 1'b0; write_n = 1'b1; address = 3'd2;
      start_req = 1;
   endtask

   task automatic run_cmd(input logic [5:0] idx, input bit resp_en, input bit crc_ign,
                          input bit card_valid, input logic [47:0] cf, input int delay,
                          input bit midsend);
      logic [31:0] st, v, new_arg;
      bit          got_done, busy_ok, e_to, e_ce, e_fe;
      int          exp_rises;
      start_cmd(idx, resp_en, crc_ign, card_valid, cf, delay);
      if (midsend) begin
         repeat (40) @(negedge clk);
         bus_write(3'd1, {24'd0, 2'b00, ~idx});
         new_arg = $urandom;
         bus_write(3'd0, new_arg);
         m_arg = new_arg;
         address = 3'd2;
      end
      @(negedge clk);
      got_done = 0; busy_ok = 1; st = '0;
      for (int c = 0; c < 3000 && !got_done; c++) begin
         @(negedge clk); #1;
         st = readdata;
         if (st[1]) got_done = 1;
         else if (!st[0]) busy_ok = 0;
      end
      check("done_within_bound", got_done, 1);
      check("busy_while_running", busy_ok, 1);

      e_to = 0; e_ce = 0; e_fe = 0;
      if (resp_en && card_valid) begin
         e_fe = (cf[46] !== 1'b0) || (cf[0] !== 1'b1);
         e_ce = !crc_ign && (ref_crc7(cf[47:8]) != cf[7:1]);
         m_resp = cf[39:8];
         m_idx  = cf[45:40];
         exp_rises = delay + 56;
      end else if (resp_en) begin
         e_to = 1;
         exp_rises = TB_TO + 8;
      end else begin
         exp_rises = 8;
      end
      if (got_done) check("sd_rises_to_done", rises_after_end, exp_rises);
      check("status", st, {27'd0, e_fe, e_ce, e_to, 1'b1, 1'b0});
      bus_read(3'd3, v); check("resp", v, m_resp);
      bus_read(3'd4, v); check("resp_idx", v, {26'd0, m_idx});
      bus_read(3'd0, v); check("arg", v, m_arg);
   endtask

   initial begin
      logic [31:0] v, a;
      logic [47:0] cf;
      logic [5:0]  idx;
      bit          re, ci, cv;
      int          kind, c;

      reset = 1'b1; cmd_in = 1'b1; address = '0; chipselect = 1'b0;
      write_n = 1'b1; writedata = '0;
      repeat (4) @(posedge clk);
      #1;
      check("reset_readdata", readdata, 0);
      check("reset_sd_clk", sd_clk, 0);
      check("reset_cmd_oe", cmd_oe, 0);
      check("reset_cmd_out", cmd_out, 1);
      @(negedge clk); reset = 1'b0;
      bus_read(3'd0, v); check("reset_arg", v, 0);
      bus_read(3'd2, v); check("reset_status", v, 0);
      bus_read(3'd3, v); check("reset_resp", v, 0);
      bus_read(3'd4, v); check("reset_resp_idx", v, 0);

      // hand-computed values that pin the reference model
      check("model_cmd0_frame", make_cmd_frame(6'd0, 32'd0), 48'h400000000095);
      check("model_cmd8_frame", make_cmd_frame(6'd8, 32'h1AA), 48'h48000001AA87);
      check("model_r7_frame", make_resp(6'd8, 32'h1AA), 48'h08000001AA13);

      // CMD0, no response
      bus_write(3'd0, 32'd0); m_arg = 32'd0;
      run_cmd(6'd0, 0, 0, 0, '0, 0, 0);

      // CMD8 with a correct R7 response
      bus_write(3'd0, 32'h1AA); m_arg = 32'h1AA;
      run_cmd(6'd8, 1, 0, 1, 48'h08000001AA13, 2, 0);
      bus_read(3'd3, v); check("cmd8_resp_literal", v, 32'h000001AA);
      bus_read(3'd4, v); check("cmd8_idx_literal", v, 32'd8);

      // corrupted CRC, then the same with crc_ign
      run_cmd(6'd8, 1, 0, 1, 48'h08000001AA13 ^ 48'h4, 5, 0);
      bus_read(3'd2, v); check("crc_corrupt_status_literal", v, 32'h0A);
      run_cmd(6'd8, 1, 1, 1, 48'h08000001AA13 ^ 48'h4, 0, 0);
      bus_read(3'd2, v); check("crc_ign_status_literal", v, 32'h02);

      // timeout: card never answers, RESP must keep the last response
      run_cmd(6'd8, 1, 0, 0, '0, 0, 0);
      bus_read(3'd2, v); check("timeout_status_literal", v, 32'h06);
      bus_read(3'd3, v); check("timeout_resp_kept", v, 32'h000001AA);

      // CMD and ARG writes while SEND is in flight
      bus_write(3'd0, 32'h1234_5678); m_arg = 32'h1234_5678;
      run_cmd(6'd17, 0, 0, 0, '0, 0, 1);
      run_cmd(6'd55, 1, 0, 1, make_resp(6'd55, 32'h0000_0120), 1, 1);

      // randomized transactions
      for (int t = 0; t < 14; t++) begin
         a = $urandom;
         bus_write(3'd0, a); m_arg = a;
         idx  = 6'($urandom_range(0, 63));
         re   = bit'($urandom_range(0, 1));
         ci   = bit'($urandom_range(0, 1));
         cv   = ($urandom_range(0, 4) != 0);
         cf   = make_resp(6'($urandom_range(0, 63)), $urandom);
         kind = $urandom_range(0, 5);
         if (kind == 1) cf = cf ^ (48'h2 << $urandom_range(0, 6));
         if (kind == 2) cf[46] = 1'b1;
         if (kind == 3) cf[0] = 1'b0;
         run_cmd(idx, re, ci, cv, cf, $urandom_range(0, 20), 0);
      end

      // reset during RECV aborts everything
      bus_write(3'd0, 32'h0000_1234); m_arg = 32'h0000_1234;
      start_cmd(6'd8, 1, 0, 1, make_resp(6'd8, 32'hCAFE_0001), 3);
      c = 0;
      while (card_idx < 10 && c < 2000) begin
         @(negedge clk); #1;
         c++;
      end
      check("reached_recv", card_idx >= 10, 1);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      check("abort_cmd_oe", cmd_oe, 0);
      check("abort_cmd_out", cmd_out, 1);
      check("abort_readdata", readdata, 0);
      @(negedge clk); reset = 1'b0;
      m_arg = '0; m_resp = '0; m_idx = '0;
      bus_read(3'd2, v); check("abort_status", v, 0);
      bus_read(3'd0, v); check("abort_arg", v, 0);
      bus_read(3'd3, v); check("abort_resp", v, 0);

      // engine usable again after the abort
      run_cmd(6'd0, 0, 0, 0, '0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sd_cmd_engine.md
# sd_cmd_engine

Hardware SD-card command-line engine that replaces software bit-banging of the SD CMD pin. The NIOS writes an argument and a command index over an Avalon-MM slave. The block then generates the SD clock, serialises the 48-bit command frame with CRC7, captures an optional 48-bit response, and checks it. It sits directly between the Avalon interconnect and the CMD pad tristate: `cmd_out` and `cmd_oe` feed the pad driver, and `cmd_in` returns from it.

## Interface
- `CLK_DIV`, default 125: `clk` cycles per `sd_clk` half-period (50 MHz → 200 kHz).
- `TIMEOUT`, default 64: `sd_clk` rising edges to wait for a response start bit.
- `clk` in 1: single system clock.
- `reset` in 1: synchronous, active-high reset.
- `address` in 3: register select.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write strobe.
- `writedata` in 32: write data.
- `readdata` out 32: registered read data, latency 1.
- `sd_clk` out 1: SD card clock.
- `cmd_out` out 1: CMD pad output value.
- `cmd_oe` out 1: CMD pad output enable (1 = drive).
- `cmd_in` in 1: CMD pad input.

## Operation
- Register map:
  - 0 ARG (R/W, 32 bits).
  - 1 CMD (W): bits [5:0] index, bit 6 `resp_en`, bit 7 `crc_ign`. Writing CMD starts a transaction.
  - 2 STATUS (R): bit 0 `busy`, bit 1 `done`, bit 2 `timeout`, bit 3 `crc_err`, bit 4 `frame_err`.
  - 3 RESP (R): response bits [39:8].
  - 4 RESP_IDX (R): response bits [45:40] in [5:0].
  - Unused bits and addresses read 0.
- SD clock generation:
  - A divider counts 0..CLK_DIV-1. At the terminal count `sd_clk` toggles; it is free-running.
  - `tick_fall` is a one-cycle pulse on 1→0; `tick_rise` is a one-cycle pulse on 0→1.
  - Outputs change only on `tick_fall`. Inputs are sampled only on `tick_rise`.
- Command frame, transmitted MSB first: 0, 1, index[5:0], ARG[31:0], CRC7[6:0], 1.
  - CRC7 polynomial is x^7+x^3+1, initial value 0, computed over the first 40 bits.
- FSM states: IDLE, SEND, WAIT, RECV, GAP.
  - **IDLE:** `cmd_oe`=0, `cmd_out`=1. A CMD write latches index/flags, clears `done`/`timeout`/`crc_err`/`frame_err`, sets `busy`, and moves to SEND.
  - **SEND:** at each `tick_fall`, drive the next frame bit with `cmd_oe`=1. On the `tick_fall` after bit 48, set `cmd_oe`=0 and `cmd_out`=1. Go to WAIT if `resp_en`, otherwise to GAP.
  - **WAIT:** at each `tick_rise`, sample `cmd_in`.
    - If the sample is 0, record the start bit and go to RECV.
    - After TIMEOUT samples with no 0, set `timeout` and go to GAP.
  - **RECV:** shift in 47 more bits on `tick_rise`. When the frame is complete:
    - Set `frame_err` if bit 46 ≠ 0 or bit 0 ≠ 1.
    - Set `crc_err` if `crc_ign`=0 and CRC7(bits 47..8) ≠ bits 7..1.
    - Load RESP and RESP_IDX, then go to GAP.
  - **GAP:** count 8 `sd_clk` rising edges (Ncc), then clear `busy`, set `done`, and return to IDLE.
- A CMD write while `busy`=1 is ignored. An ARG write while busy updates ARG but does not affect the frame in flight, because the frame is latched at start.
- RESP and RESP_IDX hold their values until the next response is received. A transaction without a response leaves them unchanged.

## Timing
- Reset values:
  - `readdata`=0, `sd_clk`=0, `cmd_oe`=0, `cmd_out`=1.
  - ARG/RESP/RESP_IDX=0, all STATUS bits 0, FSM in IDLE, divider=0.
- Reset asserted mid-transaction aborts immediately. On the next edge `cmd_oe`=0 and no partial status is reported.
- Register writes take effect on the clock edge on which `chipselect`=1 and `write_n`=0.
- `readdata` is re-registered every cycle from `address`. If a STATUS read coincides with a status update, it returns the pre-update value.
- The first command bit is driven at the first `tick_fall` following the CMD write.
- Command transmission takes 48 `sd_clk` periods. The shortest no-response transaction is 48+8 periods plus up to one period of alignment.

## Test plan
- **CMD0:** ARG=0, CMD=0x00 → the pin sequence equals 0x400000000095 MSB first; `cmd_oe` drops after the end bit; `done`=1 after 8 more clocks; `busy` reads 1 throughout.
- **CMD8 with response:** ARG=0x1AA, CMD=0x48 → transmit 0x48000001AA87. The card model returns 0x08000001AA13 → RESP=0x000001AA, RESP_IDX=8, `crc_err`=0, `frame_err`=0.
- **Corrupted CRC:** same as the CMD8 response but with CRC bits flipped → `crc_err`=1. Repeating with `crc_ign`=1 (CMD=0xC8) → `crc_err`=0.
- **Timeout:** CMD=0x48 with `cmd_in` held at 1 → `timeout`=1 after exactly 64 rising edges; `done`=1; RESP unchanged.
- **Busy protection and reset:** a CMD write mid-SEND is ignored (the frame is unchanged). Asserting `reset` during RECV → the next cycle shows `cmd_oe`=0, STATUS=0, `readdata`=0.
- **Clock ratio:** with CLK_DIV=2, `sd_clk` has a period of 4 `clk` cycles, and `cmd_out` changes only on cycles where `sd_clk` falls.
